// File: rtl/dma_arb_pkg.sv
// rtl/dma_arb_pkg.sv - shared types and priority helper for the DMA channel arbiter
//
// Purpose: arbiter FSM state type, channel-count limits and the rotating
//          priority pick used by dma_rot_prio_enc.
// Contents:
//   arb_state_t  IDLE / REQ / GRANT / REL hold-sequencer states
//   MAX_CH       largest supported channel count
//   MAX_CW       index width for MAX_CH channels
//   rot_pick     returns {found, index} of the first set request at or
//                after ptr, wrapping modulo num_ch
package dma_arb_pkg;

   typedef enum logic [1:0] {IDLE, REQ, GRANT, REL} arb_state_t;

   localparam int MAX_CH = 8;
   localparam int MAX_CW = 3;

   function automatic logic [MAX_CW:0] rot_pick(
      input logic [MAX_CH-1:0] req,
      input logic [MAX_CW-1:0] ptr,
      input int                num_ch
   );
      logic [MAX_CW:0]   res;
      logic [MAX_CW-1:0] ci;
      int                c;
      res = '0;
      // Walk from the farthest slot back toward ptr so the nearest
      // requester is the last one written and therefore wins.
      for (int k = MAX_CH - 1; k >= 0; k--) begin
         if (k < num_ch) begin
            c = int'(ptr) + k;
            if (c >= num_ch) begin
               c = c - num_ch;
            end
            ci = c[MAX_CW-1:0];
            if (req[ci]) begin
               res = {1'b1, ci};
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dma_rot_prio_enc.sv
// rtl/dma_rot_prio_enc.sv - combinational fixed/rotating priority encoder
//
// Purpose: picks one requesting channel. Fixed mode searches upward from
//          channel 0; rotating mode searches upward from ptr and wraps.
// Ports:
//   req     in   NUM_CH  conditioned request vector
//   ptr     in   CW      highest-priority channel in rotating mode
//   rot_en  in   1       1 = rotating, 0 = fixed (channel 0 highest)
//   any     out  1       at least one request present
//   idx     out  CW      index of the winning channel
module dma_rot_prio_enc
   import dma_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CW     = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CW-1:0]     ptr,
   input  logic              rot_en,
   output logic              any,
   output logic [CW-1:0]     idx
);

   logic [MAX_CH-1:0] req_ext;
   logic [MAX_CW-1:0] ptr_ext;
   logic [MAX_CW:0]   pick;
   logic              unused_pick_bits;

   always_comb begin
      req_ext             = '0;
      req_ext[NUM_CH-1:0] = req;
      // Fixed mode is rotating mode anchored at channel 0.
      ptr_ext             = '0;
      if (rot_en) begin
         ptr_ext[CW-1:0] = ptr;
      end
      pick = rot_pick(req_ext, ptr_ext, NUM_CH);
   end

   assign any              = pick[MAX_CW];
   assign idx              = pick[CW-1:0];
   assign unused_pick_bits = ^pick;

endmodule

// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - DMA channel arbiter and HRQ/HLDA bus-hold sequencer
//
// Purpose: synchronizes and conditions DREQ, selects a channel by fixed or
//          rotating priority, runs the hold handshake and drives DACK for
//          the granted channel until the timing FSM reports xfer_done.
// Ports:
//   CLK           in   1       system clock, rising edge
//   RESET_N       in   1       asynchronous active-low reset
//   DREQ          in   NUM_CH  external requests, polarity per dreq_low
//   HLDA          in   1       hold acknowledge from CPU
//   ctrl_disable  in   1       blocks starting a new hold sequence
//   rot_en        in   1       1 = rotating priority, 0 = fixed
//   dreq_low      in   1       1 = DREQ active low
//   dack_low      in   1       1 = DACK active low
//   mask          in   NUM_CH  masks external DREQ per channel
//   sw_req        in   NUM_CH  software requests, never masked
//   xfer_done     in   1       service of granted channel complete (pulse)
//   HRQ           out  1       hold request
//   DACK          out  NUM_CH  acknowledge, polarity per dack_low
//   grant_valid   out  1       a channel owns the bus
//   grant_ch      out  CW      granted channel index
//   prio_ptr      out  CW      current highest-priority channel
module dma_channel_arbiter
   import dma_arb_pkg::*;
#(
   parameter  int NUM_CH    = 4,
   parameter  int DREQ_SYNC = 2,
   localparam int CW        = $clog2(NUM_CH)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic              HLDA,
   input  logic              ctrl_disable,
   input  logic              rot_en,
   input  logic              dreq_low,
   input  logic              dack_low,
   input  logic [NUM_CH-1:0] mask,
   input  logic [NUM_CH-1:0] sw_req,
   input  logic              xfer_done,
   output logic              HRQ,
   output logic [NUM_CH-1:0] DACK,
   output logic              grant_valid,
   output logic [CW-1:0]     grant_ch,
   output logic [CW-1:0]     prio_ptr
);

   logic [NUM_CH-1:0] sync_q [DREQ_SYNC];
   logic [NUM_CH-1:0] dreq_sync;
   logic [NUM_CH-1:0] req;
   logic              req_any;
   logic [CW-1:0]     win_idx;

   arb_state_t        state_q, state_d;
   logic [CW-1:0]     grant_q, grant_d;
   logic [CW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     ptr_inc;
   logic              hrq_q, hrq_d;
   logic              gv_q, gv_d;
   logic [NUM_CH-1:0] dack_q, dack_d;

   // DREQ synchronizer chain; the last stage feeds request conditioning.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int s = 0; s < DREQ_SYNC; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= DREQ;
         for (int s = 1; s < DREQ_SYNC; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign dreq_sync = sync_q[DREQ_SYNC-1];

   // Mask applies to the external line only; software requests bypass it.
   assign req = ((dreq_sync ^ {NUM_CH{dreq_low}}) & ~mask) | sw_req;

   dma_rot_prio_enc #(
      .NUM_CH (NUM_CH),
      .CW     (CW)
   ) u_enc (
      .req    (req),
      .ptr    (ptr_q),
      .rot_en (rot_en),
      .any    (req_any),
      .idx    (win_idx)
   );

   assign ptr_inc = (grant_q == CW'(NUM_CH - 1)) ? '0 : grant_q + CW'(1);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (req_any && !ctrl_disable) begin
               state_d = REQ;
            end
         end
         REQ: begin
            // The winner is frozen here; later requests wait for the next cycle.
            if (HLDA) begin
               if (req_any) begin
                  state_d = GRANT;
                  grant_d = win_idx;
               end else begin
                  state_d = REL;
               end
            end
         end
         GRANT: begin
            // xfer_done has precedence over a simultaneous HLDA fall, so the
            // pointer still advances in that case. An abort leaves it alone.
            if (xfer_done) begin
               state_d = REL;
               if (rot_en) begin
                  ptr_d = ptr_inc;
               end
            end else if (!HLDA) begin
               state_d = REL;
            end
         end
         REL: begin
            if (!HLDA) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      hrq_d = (state_d == REQ) || (state_d == GRANT);
      gv_d  = (state_d == GRANT);
      for (int i = 0; i < NUM_CH; i++) begin
         dack_d[i] = gv_d && (grant_d == CW'(i));
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         hrq_q   <= 1'b0;
         gv_q    <= 1'b0;
         dack_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         hrq_q   <= hrq_d;
         gv_q    <= gv_d;
         dack_q  <= dack_d;
      end
   end

   assign HRQ         = hrq_q;
   assign grant_valid = gv_q;
   assign grant_ch    = grant_q;
   assign prio_ptr    = ptr_q;
   // Polarity applied after the register so DACK shows the inactive level
   // for the present dack_low setting even while held in reset.
   assign DACK        = dack_q ^ {NUM_CH{dack_low}};

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - self-checking bench for dma_channel_arbiter
module tb_dma_channel_arbiter;

   localparam int N = 4;

   logic         CLK = 1'b0;
   logic         RESET_N = 1'b0;
   logic [N-1:0] DREQ = '0;
   logic         HLDA = 1'b0;
   logic         ctrl_disable = 1'b0;
   logic         rot_en = 1'b0;
   logic         dreq_low = 1'b0;
   logic         dack_low = 1'b0;
   logic [N-1:0] mask = '0;
   logic [N-1:0] sw_req = '0;
   logic         xfer_done = 1'b0;
   logic         HRQ;
   logic [N-1:0] DACK;
   logic         grant_valid;
   logic [1:0]   grant_ch;
   logic [1:0]   prio_ptr;

   int compared = 0;
   int mismatched = 0;

   dma_channel_arbiter #(
      .NUM_CH    (N),
      .DREQ_SYNC (2)
   ) dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .DREQ         (DREQ),
      .HLDA         (HLDA),
      .ctrl_disable (ctrl_disable),
      .rot_en       (rot_en),
      .dreq_low     (dreq_low),
      .dack_low     (dack_low),
      .mask         (mask),
      .sw_req       (sw_req),
      .xfer_done    (xfer_done),
      .HRQ          (HRQ),
      .DACK         (DACK),
      .grant_valid  (grant_valid),
      .grant_ch     (grant_ch),
      .prio_ptr     (prio_ptr)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       dl;
      logic       ak;
      logic       dis;
      logic [3:0] dreq;
      logic [3:0] msk;
      logic [3:0] sw;
      logic       exp_hrq;
      int         exp_ch;
      logic [3:0] exp_dack;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic add_vec(input logic dl, input logic ak, input logic dis, input logic [3:0] dreq,
                          input logic [3:0] msk, input logic [3:0] sw, input logic eh,
                          input int ch, input logic [3:0] dk);
      vec_t v;
      v.dl = dl; v.ak = ak; v.dis = dis; v.dreq = dreq; v.msk = msk; v.sw = sw;
      v.exp_hrq = eh; v.exp_ch = ch; v.exp_dack = dk;
      vq.push_back(v);
   endtask

   task automatic do_reset();
      RESET_N = 1'b0; HLDA = 1'b0; xfer_done = 1'b0; DREQ = '0; sw_req = '0;
      mask = '0; ctrl_disable = 1'b0;
      repeat (2) step();
      RESET_N = 1'b1;
   endtask

   task automatic wait_hrq(input string name);
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!HRQ && n < 40);
      chk(name, HRQ, 1);
   endtask

   // One hold sequence: HLDA dly cycles after HRQ, then either xfer_done or an HLDA abort.
   task automatic run_service(input string tag, input int dly, input bit abort, input int exp_ch);
      logic [3:0] oh;
      wait_hrq({tag, "_hrq"});
      for (int i = 0; i < dly; i++) step();
      HLDA = 1'b1;
      @(negedge CLK);
      chk({tag, "_gv_lat"}, grant_valid, 0);
      step();
      @(negedge CLK);
      oh = 4'(1 << exp_ch);
      chk({tag, "_gv"}, grant_valid, 1);
      chk({tag, "_ch"}, grant_ch, exp_ch);
      chk({tag, "_dack"}, DACK, oh ^ {4{dack_low}});
      step();
      if (abort) HLDA = 1'b0;
      else xfer_done = 1'b1;
      @(negedge CLK);
      chk({tag, "_gv_hold"}, grant_valid, 1);
      step();
      xfer_done = 1'b0;
      HLDA = 1'b0;
      @(negedge CLK);
      chk({tag, "_gv_end"}, grant_valid, 0);
      chk({tag, "_hrq_end"}, HRQ, 0);
      chk({tag, "_dack_end"}, DACK, {4{dack_low}});
   endtask

   task automatic apply_vec(input int i, input vec_t v);
      dreq_low = v.dl; dack_low = v.ak; DREQ = v.dreq;
      mask = '1; sw_req = '0; ctrl_disable = 1'b0;
      repeat (3) step();
      mask = v.msk; sw_req = v.sw; ctrl_disable = v.dis;
      repeat (2) step();
      @(negedge CLK);
      chk($sformatf("vec%0d_hrq", i), HRQ, v.exp_hrq);
      chk($sformatf("vec%0d_dack_idle", i), DACK, {4{v.ak}});
      if (v.exp_hrq) begin
         step();
         HLDA = 1'b1;
         step();
         @(negedge CLK);
         chk($sformatf("vec%0d_gv", i), grant_valid, 1);
         chk($sformatf("vec%0d_ch", i), grant_ch, v.exp_ch);
         chk($sformatf("vec%0d_dack", i), DACK, v.exp_dack);
         step();
         xfer_done = 1'b1;
         step();
         xfer_done = 1'b0;
         HLDA = 1'b0;
         @(negedge CLK);
         chk($sformatf("vec%0d_hrq_off", i), HRQ, 0);
         chk($sformatf("vec%0d_dack_off", i), DACK, {4{v.ak}});
      end
      mask = '1; sw_req = '0; ctrl_disable = 1'b0;
      repeat (3) step();
      @(negedge CLK);
      chk($sformatf("vec%0d_ptr", i), prio_ptr, 0);
   endtask

   function automatic int pick(input logic [3:0] r, input int ptr, input bit rot);
      int base;
      base = rot ? ptr : 0;
      for (int k = 0; k < N; k++) begin
         if (r[(base + k) % N]) return (base + k) % N;
      end
      return -1;
   endfunction

   initial begin
      logic [3:0] hist[$];
      logic [3:0] req_now, prev_req, oh;
      logic       prev_gv, prev_hrq, prev_rot, prev_xfer, prev_hlda, prev_dis;
      int         ptr_m, exp_g, low_run, grants;

      // reset values, DACK polarity while held in reset
      RESET_N = 1'b0;
      step();
      @(negedge CLK);
      chk("rst_hrq", HRQ, 0);
      chk("rst_gv", grant_valid, 0);
      chk("rst_ch", grant_ch, 0);
      chk("rst_ptr", prio_ptr, 0);
      chk("rst_dack_hi", DACK, 4'b0000);
      dack_low = 1'b1;
      #1;
      chk("rst_dack_lo", DACK, 4'b1111);
      dack_low = 1'b0;
      do_reset();

      // fixed-mode table
      add_vec(0, 0, 0, 4'b1010, 4'b0000, 4'b0000, 1, 1, 4'b0010);
      add_vec(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000);
      add_vec(0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 0, 0, 4'b0000);
      add_vec(0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 1, 0, 4'b0001);
      add_vec(1, 1, 0, 4'b1011, 4'b0000, 4'b0000, 1, 2, 4'b1011);
      add_vec(0, 1, 0, 4'b1100, 4'b0100, 4'b0000, 1, 3, 4'b0111);
      add_vec(0, 0, 0, 4'b1111, 4'b1110, 4'b0100, 1, 0, 4'b0001);
      add_vec(1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0000);
      add_vec(0, 0, 0, 4'b0000, 4'b1111, 4'b1000, 1, 3, 4'b1000);
      add_vec(0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 0, 4'b0000);
      for (int i = 0; i < vq.size(); i++) apply_vec(i, vq[i]);

      // DREQ edge to HRQ latency, then a fixed-mode service
      dreq_low = 1'b0; dack_low = 1'b0; rot_en = 1'b0;
      do_reset();
      step();
      DREQ = 4'b1010;
      step(); step();
      @(negedge CLK);
      chk("dreq_lat_early", HRQ, 0);
      step();
      @(negedge CLK);
      chk("dreq_lat", HRQ, 1);
      run_service("fix", 2, 0, 1);
      chk("fix_ptr", prio_ptr, 0);

      // rotating order 0,1,2,3 then wrap
      do_reset();
      rot_en = 1'b1;
      DREQ = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         run_service($sformatf("rot%0d", i), 1, 0, i % N);
         chk($sformatf("rot%0d_ptr", i), prio_ptr, (i + 1) % N);
      end
      // abort with prio_ptr at 2 leaves it there
      run_service("abort", 1, 1, 2);
      chk("abort_ptr", prio_ptr, 2);

      // asynchronous reset in the middle of a grant
      dack_low = 1'b1;
      wait_hrq("arst_hrq");
      step();
      HLDA = 1'b1;
      step();
      @(negedge CLK);
      chk("arst_pre_gv", grant_valid, 1);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("arst_hrq", HRQ, 0);
      chk("arst_dack", DACK, 4'b1111);
      chk("arst_gv", grant_valid, 0);
      HLDA = 1'b0; DREQ = '0; rot_en = 1'b0; dack_low = 1'b0;
      step();
      RESET_N = 1'b1;
      @(negedge CLK);
      chk("arst_post_hrq", HRQ, 0);
      chk("arst_post_ptr", prio_ptr, 0);
      chk("arst_post_dack", DACK, 4'b0000);
      step();
      sw_req = 4'b0001;
      @(negedge CLK);
      chk("sw_lat_early", HRQ, 0);
      step();
      @(negedge CLK);
      chk("sw_lat", HRQ, 1);
      run_service("sw", 1, 0, 0);
      sw_req = '0;

      // randomized run against a transaction-level model
      dreq_low = 1'b0; dack_low = 1'b0; rot_en = 1'b1;
      do_reset();
      hist = '{4'b0000, 4'b0000};
      prev_gv = 0; prev_hrq = 0; prev_rot = rot_en; prev_xfer = 0; prev_hlda = 0;
      prev_dis = 0; prev_req = '0;
      ptr_m = 0; exp_g = 0; low_run = 100; grants = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge CLK);
         req_now = ((hist[0] ^ {4{dreq_low}}) & ~mask) | sw_req;
         if (prev_gv) chk("rand_gv_hold", grant_valid, !(prev_xfer || !prev_hlda));
         else chk("rand_gv_start", grant_valid, prev_hrq && prev_hlda && (prev_req != 0));
         if (grant_valid && !prev_gv) begin
            exp_g = pick(prev_req, ptr_m, prev_rot);
            chk("rand_grant_ch", grant_ch, exp_g);
            grants++;
         end
         if (!grant_valid && prev_gv && prev_xfer && prev_rot) ptr_m = (exp_g + 1) % N;
         chk("rand_ptr", prio_ptr, ptr_m);
         oh = grant_valid ? 4'(1 << exp_g) : 4'b0000;
         chk("rand_dack", DACK, oh ^ {4{dack_low}});
         chk("rand_hrq_gv", HRQ | !grant_valid, 1);
         if (HRQ && !prev_hrq) begin
            chk("rand_hrq_gap", low_run >= 2, 1);
            chk("rand_hrq_cause", (prev_req != 0) && !prev_dis, 1);
         end
         low_run = HRQ ? 0 : low_run + 1;
         prev_gv = grant_valid; prev_hrq = HRQ; prev_req = req_now; prev_rot = rot_en;
         prev_xfer = xfer_done; prev_hlda = HLDA; prev_dis = ctrl_disable;
         void'(hist.pop_front());
         hist.push_back(DREQ);

         step();
         if ($urandom_range(0, 7) == 0) DREQ = 4'($urandom);
         if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
         sw_req = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 49) == 0) rot_en = ~rot_en;
         if ($urandom_range(0, 99) == 0) dreq_low = ~dreq_low;
         if ($urandom_range(0, 29) == 0) dack_low = ~dack_low;
         ctrl_disable = ($urandom_range(0, 9) == 0);
         xfer_done = 1'b0;
         if (prev_hrq && !prev_hlda) begin
            if ($urandom_range(0, 2) == 0) HLDA = 1'b1;
         end else if (!prev_hrq && prev_hlda) begin
            if ($urandom_range(0, 1) == 0) HLDA = 1'b0;
         end
         if (prev_gv && prev_hlda && !prev_xfer) begin
            if ($urandom_range(0, 39) == 0) HLDA = 1'b0;
            if ($urandom_range(0, 2) == 0) xfer_done = 1'b1;
         end
      end
      chk("rand_grants_seen", grants > 50, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
